immediate_packer: RTL and testbench
===================================

Name: immediate_packer

Overview:
- Inverse of the decode-side immediate extender: turns a full 16-bit constant plus destination register into the shortest legal WISC instruction sequence that materialises it.
- Emits either a single LBI, or LBI followed by SLBI, over a valid/ready stream.
- Sits between the constant/microcode source (test loader, trap-vector setup) and the fetch-stage instruction insertion mux.

Parameters:
- SHORT_FORM, 1, 1 = emit lone LBI when the value fits signed 8-bit; 0 = always emit the two-beat sequence.
- LBI_OPC, 5'b11000, opcode placed in bits [15:11] of the LBI beat.
- SLBI_OPC, 5'b10010, opcode placed in bits [15:11] of the SLBI beat.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of any in-flight sequence
- req_valid  in  1  constant request present
- req_ready  out  1  packer can accept a request
- req_value  in  16  constant to materialise
- req_rd  in  3  destination register
- instr_valid  out  1  instruction beat present
- instr_ready  in  1  consumer takes the beat
- instr_word  out  16  encoded instruction
- instr_last  out  1  beat is the final instruction of the sequence
- beats_emitted  out  16  count of beats handed off (instr_valid && instr_ready); wraps 0xFFFF -> 0x0000

Behaviour:
- Reset (async, rst=1): state IDLE, req_ready=1, instr_valid=0, instr_word=0x0000, instr_last=0, beats_emitted=0, captured value/rd cleared.
- FSM states:
  - IDLE: req_ready=1, instr_valid=0. On req_valid && !flush, capture value, rd and fits = fits_immd(value, loc=8-bit, Signed=1). Next state is EMIT_FIRST.
  - EMIT_FIRST: req_ready=0, instr_valid=1.
    - Short form (SHORT_FORM && fits): instr_word = {LBI_OPC, rd, value[7:0]}, instr_last=1.
    - Otherwise: instr_word = {LBI_OPC, rd, value[15:8]}, instr_last=0.
    - On instr_ready: next state is IDLE if last, else EMIT_SECOND.
  - EMIT_SECOND: instr_word = {SLBI_OPC, rd, value[7:0]}, instr_last=1. On instr_ready, next state is IDLE.
- Correctness rule: the two-beat result is sext(hi)<<8 | zext(lo) = value. Decode-side sign/zero extension semantics are authoritative.
- Latency: the first beat appears the cycle after acceptance. The next request can be accepted the cycle after the last beat hands off. Throughput is 1 request per 2 cycles (short form) or 3 cycles (long form).
- Backpressure: while instr_valid && !instr_ready, instr_word and instr_last stay stable and the state holds.
- flush (sync, highest priority after rst):
  - Forces IDLE next cycle; instr_valid=0 that cycle.
  - A request presented in the same cycle is not accepted.
  - A beat handed off in the flush cycle still counts in beats_emitted.
- Register outputs (instr_word, instr_last, instr_valid) are driven from flops, not combinationally from inputs.
- Reset asserted mid-sequence clears everything immediately; no partial SLBI is ever emitted afterwards.

Decomposition:
- Shared package holds:
  - opcode constants LBI/SLBI;
  - ImmdLocation codes (00 = 5-bit, 01 = 8-bit, 10 = 11-bit);
  - FSM state encoding (IDLE = 2'd0, EMIT_FIRST = 2'd1, EMIT_SECOND = 2'd2).
- Sub-module fits_immd (combinational), ports inA[15:0], ImmdLocation[1:0], Signed, Fits:
  - Fits=1 when re-extending the field yields inA.
  - Reusable by the assembler/loader for other I-formats.

Test Plan:
- SHORT_FORM=1, value 0x0005, rd 3 -> single beat 0xC305, last=1; beats_emitted=1.
- value 0xFF80, rd 3 -> single beat 0xC380, last=1 (negative fits signed 8).
- value 0x1234, rd 2 -> beats 0xC212 (last=0) then 0x9234 (last=1); req_ready low throughout, high the cycle after.
- value 0x0080, rd 1 with instr_ready held low 3 cycles on each beat -> 0xC100 stable 4 cycles, then 0x9180 stable; no duplicate or lost beats.
- flush during EMIT_SECOND of value 0xABCD with req_valid=1 -> instr_valid=0 next cycle, request not accepted, beats_emitted counts only the LBI; the next request packs normally.
- rst pulse mid-sequence (async, between edges) -> outputs zero immediately; beats_emitted=0; no SLBI after release. SHORT_FORM=0 with value 0x0005 -> 0xC300 then 0x9305.

Source files
------------

// File: rtl/immediate_packer_pkg.sv
// Shared definitions for the immediate packer: opcodes, immediate field
// locations, FSM state encoding and the instruction-word assembler.
package immediate_packer_pkg;

  localparam logic [4:0] LBI_OPC_DEF  = 5'b11000;
  localparam logic [4:0] SLBI_OPC_DEF = 5'b10010;

  typedef enum logic [1:0] {
    IMMD_5  = 2'b00,
    IMMD_8  = 2'b01,
    IMMD_11 = 2'b10
  } immdLoc_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    EMIT_FIRST  = 2'd1,
    EMIT_SECOND = 2'd2
  } packState_t;

  function automatic logic [15:0] encodeInstr(input logic [4:0] opc,
                                              input logic [2:0] rd,
                                              input logic [7:0] imm);
    return {opc, rd, imm};
  endfunction

endpackage

// File: rtl/fits_immd.sv
// Combinational check: does inA survive truncation to the selected immediate
// field and re-extension (sign or zero) back to 16 bits?
module fits_immd
  import immediate_packer_pkg::*;
(
  input  logic [15:0] inA,
  input  logic [1:0]  ImmdLocation,
  input  logic        Signed,
  output logic        Fits
);

  logic [2:0] fitsSigned;
  logic [2:0] fitsUnsigned;

  // Field widths 5, 8 and 11 follow the ImmdLocation code order.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gWidth
      localparam int W = 5 + 3 * gi;
      assign fitsSigned[gi]   = (inA[15:W-1] == {(17 - W){inA[W-1]}});
      assign fitsUnsigned[gi] = (inA[15:W] == '0);
    end
  endgenerate

  always_comb begin
    Fits = 1'b0;
    case (ImmdLocation)
      IMMD_5:  Fits = Signed ? fitsSigned[0] : fitsUnsigned[0];
      IMMD_8:  Fits = Signed ? fitsSigned[1] : fitsUnsigned[1];
      IMMD_11: Fits = Signed ? fitsSigned[2] : fitsUnsigned[2];
      default: Fits = 1'b0;
    endcase
  end

endmodule

// File: rtl/immediate_packer.sv
// Packs a 16-bit constant into LBI, or LBI+SLBI, and streams the beats out
// over valid/ready. All stream outputs come straight from flops.
module immediate_packer
  import immediate_packer_pkg::*;
#(
  parameter bit         SHORT_FORM = 1'b1,
  parameter logic [4:0] LBI_OPC    = LBI_OPC_DEF,
  parameter logic [4:0] SLBI_OPC   = SLBI_OPC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_value,
  input  logic [2:0]  req_rd,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_word,
  output logic        instr_last,
  output logic [15:0] beats_emitted
);

  packState_t  stateReg, stateNext;
  logic [15:0] valueReg, valueNext;
  logic [2:0]  rdReg, rdNext;
  logic        fitsReg, fitsNext;
  logic [15:0] wordReg, wordNext;
  logic        lastReg, lastNext;
  logic        validReg, validNext;
  logic [15:0] beatsReg;
  logic        reqFits;
  logic        shortNext;

  fits_immd uFits (
    .inA          (req_value),
    .ImmdLocation (IMMD_8),
    .Signed       (1'b1),
    .Fits         (reqFits)
  );

  always_comb begin
    stateNext = stateReg;
    valueNext = valueReg;
    rdNext    = rdReg;
    fitsNext  = fitsReg;
    if (flush) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE: begin
          if (req_valid) begin
            stateNext = EMIT_FIRST;
            valueNext = req_value;
            rdNext    = req_rd;
            fitsNext  = reqFits;
          end
        end
        EMIT_FIRST:  if (instr_ready) stateNext = lastReg ? IDLE : EMIT_SECOND;
        EMIT_SECOND: if (instr_ready) stateNext = IDLE;
        default:     stateNext = IDLE;
      endcase
    end

    // Output flops are loaded from the state being entered, so a stalled beat
    // is simply recomputed from unchanged captured operands.
    shortNext = SHORT_FORM && fitsNext;
    wordNext  = '0;
    lastNext  = 1'b0;
    validNext = 1'b0;
    case (stateNext)
      EMIT_FIRST: begin
        validNext = 1'b1;
        lastNext  = shortNext;
        wordNext  = encodeInstr(LBI_OPC, rdNext,
                                shortNext ? valueNext[7:0] : valueNext[15:8]);
      end
      EMIT_SECOND: begin
        validNext = 1'b1;
        lastNext  = 1'b1;
        wordNext  = encodeInstr(SLBI_OPC, rdNext, valueNext[7:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      valueReg <= '0;
      rdReg    <= '0;
      fitsReg  <= 1'b0;
      wordReg  <= '0;
      lastReg  <= 1'b0;
      validReg <= 1'b0;
      beatsReg <= '0;
    end else begin
      stateReg <= stateNext;
      valueReg <= valueNext;
      rdReg    <= rdNext;
      fitsReg  <= fitsNext;
      wordReg  <= wordNext;
      lastReg  <= lastNext;
      validReg <= validNext;
      if (validReg && instr_ready) beatsReg <= beatsReg + 16'd1;
    end
  end

  assign req_ready     = (stateReg == IDLE);
  assign instr_valid   = validReg;
  assign instr_word    = wordReg;
  assign instr_last    = lastReg;
  assign beats_emitted = beatsReg;

endmodule

// File: tb/tb_immediate_packer.sv
// Randomised bench for immediate_packer: a short-form and an always-long-form
// instance share stimulus and are checked against a beat-queue reference model.
module tb_immediate_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        reqValid = 1'b0;
  logic [15:0] reqValue = '0;
  logic [2:0]  reqRd = '0;
  logic        instrReady = 1'b0;

  logic        readyA, validA, lastA, readyB, validB, lastB;
  logic [15:0] wordA, wordB, beatsA, beatsB;

  always #5 clk = ~clk;

  immediate_packer #(.SHORT_FORM(1'b1)) dutA (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(reqValid), .req_ready(readyA), .req_value(reqValue), .req_rd(reqRd),
    .instr_valid(validA), .instr_ready(instrReady), .instr_word(wordA),
    .instr_last(lastA), .beats_emitted(beatsA)
  );

  immediate_packer #(.SHORT_FORM(1'b0)) dutB (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(reqValid), .req_ready(readyB), .req_value(reqValue), .req_rd(reqRd),
    .instr_valid(validB), .instr_ready(instrReady), .instr_word(wordB),
    .instr_last(lastB), .beats_emitted(beatsB)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: express the constant as sext(hi)*256 + zext(lo) using plain
  // integer arithmetic; one beat when it lies in [-128,127] and short form is on.
  function automatic void expand(input bit sf, input logic [15:0] v, input logic [2:0] rd,
                                 output int n, output logic [16:0] b0, output logic [16:0] b1);
    int sv, lo, hi;
    sv = int'($signed(v));
    lo = int'(v[7:0]);
    hi = (sv - lo) / 256;
    b1 = '0;
    if (sf && sv >= -128 && sv <= 127) begin
      n  = 1;
      b0 = {1'b1, 5'b11000, rd, lo[7:0]};
    end else begin
      n  = 2;
      b0 = {1'b0, 5'b11000, rd, hi[7:0]};
      b1 = {1'b1, 5'b10010, rd, lo[7:0]};
    end
  endfunction

  logic [16:0] qA[$];
  logic [16:0] qB[$];
  logic [15:0] logA[$];
  logic [15:0] logB[$];
  logic [15:0] expBeatsA = '0;
  logic [15:0] expBeatsB = '0;

  task automatic modelStep(input bit inReset);
    int n;
    logic [16:0] b0, b1;
    bit idleA, idleB;
    if (inReset) begin
      qA.delete();
      qB.delete();
      expBeatsA = '0;
      expBeatsB = '0;
    end else begin
      idleA = (qA.size() == 0);
      idleB = (qB.size() == 0);
      if (validA && instrReady) logA.push_back(wordA);
      if (validB && instrReady) logB.push_back(wordB);
      if (!idleA && instrReady) begin void'(qA.pop_front()); expBeatsA++; end
      if (!idleB && instrReady) begin void'(qB.pop_front()); expBeatsB++; end
      if (flush) begin
        qA.delete();
        qB.delete();
      end else begin
        if (reqValid && idleA) begin
          expand(1'b1, reqValue, reqRd, n, b0, b1);
          qA.push_back(b0);
          if (n == 2) qA.push_back(b1);
        end
        if (reqValid && idleB) begin
          expand(1'b0, reqValue, reqRd, n, b0, b1);
          qB.push_back(b0);
          if (n == 2) qB.push_back(b1);
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) modelStep(rst);

  task automatic compareOutputs();
    check("reqReadyA", 32'(readyA), 32'(qA.size() == 0));
    check("instrValidA", 32'(validA), 32'(qA.size() != 0));
    check("beatsA", 32'(beatsA), 32'(expBeatsA));
    if (qA.size() != 0) begin
      check("wordA", 32'(wordA), 32'(qA[0][15:0]));
      check("lastA", 32'(lastA), 32'(qA[0][16]));
    end
    check("reqReadyB", 32'(readyB), 32'(qB.size() == 0));
    check("instrValidB", 32'(validB), 32'(qB.size() != 0));
    check("beatsB", 32'(beatsB), 32'(expBeatsB));
    if (qB.size() != 0) begin
      check("wordB", 32'(wordB), 32'(qB[0][15:0]));
      check("lastB", 32'(lastB), 32'(qB[0][16]));
    end
  endtask

  always @(negedge clk) if (!rst) compareOutputs();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while (!(readyA && readyB) && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) begin
      nChecks++;
      nFails++;
      $display("FAIL idleTimeout: readyA=%0b readyB=%0b after %0d cycles", readyA, readyB, k);
    end
  endtask

  task automatic send(input logic [15:0] v, input logic [2:0] rd);
    waitIdle();
    reqValid = 1'b1;
    reqValue = v;
    reqRd    = rd;
    tick();
    reqValid = 1'b0;
    waitIdle();
  endtask

  initial begin
    int n, baseA, baseB;
    logic [16:0] b0, b1;
    logic [15:0] edgeVals[6];
    edgeVals = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F, 16'h0000, 16'hFFFF};

    // Pin the reference model with hand-computed encodings.
    expand(1'b1, 16'h0005, 3'd3, n, b0, b1);
    check("modelShort", {15'b0, b0}, {15'b0, 17'h1C305});
    check("modelShortN", 32'(n), 32'd1);
    expand(1'b0, 16'hFF80, 3'd3, n, b0, b1);
    check("modelNegHi", {15'b0, b0}, {15'b0, 17'h0C3FF});
    check("modelNegLo", {15'b0, b1}, {15'b0, 17'h19380});
    expand(1'b1, 16'h0080, 3'd1, n, b0, b1);
    check("modelBoundary", {15'b0, b0}, {15'b0, 17'h0C100});

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rstWordA", 32'(wordA), 32'h0);
    check("rstLastA", 32'(lastA), 32'h0);
    check("rstValidA", 32'(validA), 32'h0);
    check("rstReadyA", 32'(readyA), 32'h1);
    check("rstBeatsA", 32'(beatsA), 32'h0);

    instrReady = 1'b1;
    baseA = logA.size(); baseB = logB.size();
    send(16'h0005, 3'd3);
    check("shortWord", 32'(logA[baseA]), 32'hC305);
    check("shortBeats", 32'(beatsA), 32'd1);
    check("longFormHi", 32'(logB[baseB]), 32'hC300);
    check("longFormLo", 32'(logB[baseB+1]), 32'h9305);

    baseA = logA.size();
    send(16'hFF80, 3'd3);
    check("negShortWord", 32'(logA[baseA]), 32'hC380);
    check("negShortCount", 32'(logA.size() - baseA), 32'd1);

    baseA = logA.size();
    send(16'h1234, 3'd2);
    check("twoBeatHi", 32'(logA[baseA]), 32'hC212);
    check("twoBeatLo", 32'(logA[baseA+1]), 32'h9234);

    // Backpressure: three stalled cycles ahead of each handoff.
    baseA = logA.size();
    waitIdle();
    instrReady = 1'b0;
    reqValid = 1'b1; reqValue = 16'h0080; reqRd = 3'd1;
    tick();
    reqValid = 1'b0;
    for (int beat = 0; beat < 2; beat++) begin
      repeat (3) tick();
      instrReady = 1'b1;
      tick();
      instrReady = 1'b0;
    end
    check("stallHi", 32'(logA[baseA]), 32'hC100);
    check("stallLo", 32'(logA[baseA+1]), 32'h9180);
    check("stallCount", 32'(logA.size() - baseA), 32'd2);

    // Flush while the SLBI beat is pending, with a competing request.
    waitIdle();
    baseA = logA.size();
    reqValid = 1'b1; reqValue = 16'hABCD; reqRd = 3'd5;
    tick();
    reqValid = 1'b0; instrReady = 1'b1;
    tick();
    check("preFlushWord", 32'(wordA), 32'h95CD);
    flush = 1'b1; reqValid = 1'b1; reqValue = 16'h0011; instrReady = 1'b0;
    tick();
    flush = 1'b0; reqValid = 1'b0;
    check("flushValidA", 32'(validA), 32'h0);
    check("flushValidB", 32'(validB), 32'h0);
    check("flushReadyA", 32'(readyA), 32'h1);
    check("flushLbiOnly", 32'(logA.size() - baseA), 32'd1);
    check("flushLbiWord", 32'(logA[baseA]), 32'hC5AB);
    instrReady = 1'b1;
    baseA = logA.size(); baseB = logB.size();
    send(16'h0042, 3'd6);
    check("postFlushA", 32'(logA[baseA]), 32'hC642);
    check("postFlushBHi", 32'(logB[baseB]), 32'hC600);
    check("postFlushBLo", 32'(logB[baseB+1]), 32'h9642);

    // Asynchronous reset between clock edges in the middle of a sequence.
    instrReady = 1'b0;
    reqValid = 1'b1; reqValue = 16'h1234; reqRd = 3'd2;
    tick();
    reqValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("asyncValidA", 32'(validA), 32'h0);
    check("asyncWordA", 32'(wordA), 32'h0);
    check("asyncLastA", 32'(lastA), 32'h0);
    check("asyncBeatsA", 32'(beatsA), 32'h0);
    check("asyncReadyA", 32'(readyA), 32'h1);
    check("asyncValidB", 32'(validB), 32'h0);
    baseA = logA.size(); baseB = logB.size();
    tick();
    rst = 1'b0;
    instrReady = 1'b1;
    repeat (4) tick();
    check("noSlbiAfterRstA", 32'(logA.size() - baseA), 32'd0);
    check("noSlbiAfterRstB", 32'(logB.size() - baseB), 32'd0);

    // Random traffic with backpressure and occasional flushes.
    for (int c = 0; c < 1500; c++) begin
      reqValid   = ($urandom_range(0, 1) == 1);
      instrReady = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 31) == 0);
      reqRd      = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       reqValue = edgeVals[$urandom_range(0, 5)];
        1:       reqValue = 16'($signed(9'($urandom_range(0, 511))));
        default: reqValue = 16'($urandom_range(0, 65535));
      endcase
      tick();
    end
    flush = 1'b0; reqValid = 1'b0; instrReady = 1'b1;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
